// File: rtl/even_count_checker.sv
// Checks that a 4-bit source counts by two (mod 16), declaring lock after
// LOCK_THRESH in-sequence samples and tolerating one glitch once locked.
module even_count_checker #(
    parameter int LOCK_THRESH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count_in,
    input  logic       count_valid,
    output logic       locked,
    output logic       error,
    output logic       err_sticky,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {SEARCH, LOCKED, LOST} state_t;

    localparam logic [3:0] THRESH = 4'(LOCK_THRESH);

    state_t     state;
    logic [3:0] exp_val;
    logic [3:0] run;
    logic [3:0] nxt;
    logic       match;

    assign nxt   = count_in + 4'd2;
    assign match = (count_in == exp_val);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SEARCH;
            exp_val    <= 4'd0;
            run        <= 4'd0;
            locked     <= 1'b0;
            error      <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            error <= 1'b0;
            if (count_valid) begin
                if (count_in[0]) begin
                    // Odd samples can never belong to the sequence; exp is kept.
                    error      <= 1'b1;
                    err_sticky <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    state      <= SEARCH;
                    locked     <= 1'b0;
                    run        <= 4'd0;
                end else begin
                    unique case (state)
                        SEARCH: begin
                            exp_val <= nxt;
                            if (run != 4'd0 && match) begin
                                run <= run + 4'd1;
                                if (run + 4'd1 == THRESH) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                run <= 4'd1;
                            end
                        end
                        LOCKED: begin
                            if (match) begin
                                exp_val <= nxt;
                            end else begin
                                // The bad sample still occupies one slot of the sequence.
                                error      <= 1'b1;
                                err_sticky <= 1'b1;
                                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                                exp_val    <= exp_val + 4'd2;
                                state      <= LOST;
                            end
                        end
                        LOST: begin
                            exp_val <= nxt;
                            if (match) begin
                                state <= LOCKED;
                            end else begin
                                error      <= 1'b1;
                                err_sticky <= 1'b1;
                                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                                state      <= SEARCH;
                                locked     <= 1'b0;
                                run        <= 4'd1;
                            end
                        end
                        default: begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            run    <= 4'd0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_even_count_checker.sv
// Randomized and directed bench for even_count_checker against a behavioural model.
module tb_even_count_checker;

    localparam int LT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic       count_valid = 1'b0;
    logic       locked, error, err_sticky;
    logic [7:0] err_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    even_count_checker #(.LOCK_THRESH(LT)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
        .locked(locked), .error(error), .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: 0 = searching, 1 = locked, 2 = lost one sample.
    int m_state, m_run, m_exp, m_errs;
    bit m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = 0; m_run = 0; m_exp = 0; m_errs = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (count_valid) begin
                int s;
                bit hit;
                s   = int'(count_in);
                hit = (s == m_exp);
                if (s % 2 == 1) begin
                    m_err = 1; m_state = 0; m_run = 0;
                end else if (m_state == 0) begin
                    m_run = (m_run > 0 && hit) ? m_run + 1 : 1;
                    m_exp = (s + 2) % 16;
                    if (m_run >= LT) m_state = 1;
                end else if (hit) begin
                    m_state = 1; m_exp = (s + 2) % 16;
                end else if (m_state == 1) begin
                    m_err = 1; m_state = 2; m_exp = (m_exp + 2) % 16;
                end else begin
                    m_err = 1; m_state = 0; m_run = 1; m_exp = (s + 2) % 16;
                end
                if (m_err) m_errs++;
            end
        end
    end

    function automatic int m_cnt();
        return (m_errs > 255) ? 255 : m_errs;
    endfunction

    task automatic cmp(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("locked", int'(locked), (m_state != 0) ? 1 : 0);
            cmp("error", int'(error), int'(m_err));
            cmp("err_sticky", int'(err_sticky), (m_errs > 0) ? 1 : 0);
            cmp("err_cnt", int'(err_cnt), m_cnt());
        end
    end

    // Literal expectations pin both the DUT and the model.
    task automatic expect_lit(input string name, input int lk, input int er, input int cnt);
        cmp({name, "_locked"}, int'(locked), lk);
        cmp({name, "_error"}, int'(error), er);
        cmp({name, "_cnt"}, int'(err_cnt), cnt);
        cmp({name, "_model_locked"}, (m_state != 0) ? 1 : 0, lk);
        cmp({name, "_model_cnt"}, m_cnt(), cnt);
    endtask

    task automatic step(input bit v, input int s);
        @(negedge clk);
        count_valid = v;
        count_in    = 4'(s);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        cmp("rst_locked", int'(locked), 0);
        cmp("rst_error", int'(error), 0);
        cmp("rst_sticky", int'(err_sticky), 0);
        cmp("rst_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int src;
        count_valid = 1'b0;
        #12;
        cmp("por_locked", int'(locked), 0);
        cmp("por_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        chk_on = 1'b1;

        // Locking and wrap-around
        step(1, 0); step(1, 2);
        expect_lit("lock2", 0, 0, 0);
        step(1, 4);
        expect_lit("lock3", 1, 0, 0);
        for (int v = 6; v <= 18; v += 2) step(1, v % 16);
        expect_lit("wrap", 1, 0, 0);

        // Loss of lock: 4,12,0 then 2,4
        step(1, 4); step(1, 12);
        expect_lit("loss12", 1, 1, 1);
        step(1, 0);
        expect_lit("loss0", 0, 1, 2);
        step(1, 2); step(1, 4);
        expect_lit("relock", 1, 0, 2);

        // Glitch recovery: 6 (in seq), 8,10,6,14
        step(1, 6); step(1, 8); step(1, 10); step(1, 6);
        expect_lit("glitch", 1, 1, 3);
        step(1, 14);
        expect_lit("recover", 1, 0, 3);
        cmp("recover_sticky", int'(err_sticky), 1);

        // Odd value then relock
        step(1, 5);
        expect_lit("odd", 0, 1, 4);
        step(1, 0); step(1, 2);
        expect_lit("odd_pre", 0, 0, 4);
        step(1, 4);
        expect_lit("odd_relock", 1, 0, 4);

        // Stalls between samples, then reset while locked with err_cnt=3
        do_reset();
        step(1, 0); step(0, 7); step(1, 2); step(0, 9);
        expect_lit("stall", 0, 0, 0);
        step(1, 4);
        expect_lit("stall_lock", 1, 0, 0);
        step(1, 1); step(1, 3); step(1, 5);
        step(1, 0); step(1, 2); step(1, 4);
        expect_lit("pre_rst", 1, 0, 3);
        count_valid = 1'b1;
        do_reset();

        // Reset while LOST with an error pulse outstanding
        step(1, 0); step(1, 2); step(1, 4); step(1, 10);
        expect_lit("lost", 1, 1, 1);
        do_reset();

        // Held-in-reset source repeats 0
        step(1, 0); step(1, 0); step(1, 0);
        expect_lit("repeat", 0, 0, 0);

        // Saturation
        for (int i = 0; i < 300; i++) step(1, 2 * ($urandom_range(0, 7)) + 1);
        expect_lit("sat", 0, 1, 255);
        cmp("sat_sticky", int'(err_sticky), 1);

        // Randomized traffic
        do_reset();
        src = 0;
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 1) begin
                do_reset();
            end else if (r < 15) begin
                step(0, $urandom_range(0, 15));
            end else if (r < 80) begin
                step(1, src);
                src = (src + 2) % 16;
            end else if (r < 90) begin
                int e;
                e = 2 * $urandom_range(0, 7);
                step(1, e);
                if ($urandom_range(0, 1) == 1) src = (e + 2) % 16;
            end else if (r < 95) begin
                step(1, 2 * $urandom_range(0, 7) + 1);
            end else begin
                step(1, (src + 14) % 16);
            end
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/even_count_checker.md
EVEN_COUNT_CHECKER -- requirements
Module: even_count_checker

Interface
REQ-001 SHALL have parameter LOCK_THRESH, default 3, which is the number of consecutive in-sequence samples needed to declare lock (legal range 2..15).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have port count_in  input  4  sample from an even-counter source.
REQ-005 SHALL have port count_valid  input  1  count_in is sampled on a rising edge only when this is 1.
REQ-006 SHALL have port locked  output  1  checker has accepted the source as a valid even sequence.
REQ-007 SHALL have port error  output  1  one-cycle pulse per erroneous sample.
REQ-008 SHALL have port err_sticky  output  1  set by any error and cleared only by reset.
REQ-009 SHALL have port err_cnt  output  8  count of erroneous samples, saturating at 255.

Function
REQ-010 SHALL hold an internal expected value exp[3:0], a run counter run[3:0] and a state in {SEARCH, LOCKED, LOST}.
REQ-011 SHALL register all outputs; a sample captured on edge N is reflected in the outputs after edge N.
REQ-012 SHALL hold all state, counters and outputs unchanged, and drive error=0, on any edge where count_valid=0.
REQ-013 SHALL compute the next expected value as (sample + 2) mod 16, so a sample of 14 gives exp=0 (wrap-around is legal, not an error).
REQ-014 SHALL treat an odd sample (count_in[0]=1) in any state as follows: error=1, err_cnt increments, state=SEARCH, run=0, exp unchanged.
REQ-015 In SEARCH with run=0, an even sample SHALL set run=1 and exp=sample+2, with no error.
REQ-016 In SEARCH with run>0, an even sample equal to exp SHALL increment run and advance exp; when run reaches LOCK_THRESH the state SHALL become LOCKED.
REQ-017 In SEARCH, an even sample not equal to exp SHALL reseed: run=1, exp=sample+2, with no error.
REQ-018 In LOCKED, a sample equal to exp SHALL advance exp and keep LOCKED, with no error.
REQ-019 In LOCKED, an even sample not equal to exp SHALL give error=1, increment err_cnt, set exp=exp+2 (the bad sample consumes one slot) and move to LOST.
REQ-020 In LOST, a sample equal to exp SHALL return the state to LOCKED (single-glitch recovery) and advance exp, with no error.
REQ-021 In LOST, an even sample not equal to exp SHALL give error=1, increment err_cnt, move to SEARCH with run=1 and exp=sample+2.
REQ-022 SHALL drive locked=1 iff the state is LOCKED or LOST.
REQ-023 SHALL hold err_cnt at 255 on further errors; error and err_sticky still assert.
REQ-024 SHALL not saturate run above LOCK_THRESH; run is don't-care outside SEARCH.
REQ-025 SHALL treat a repeated sample (a source held in reset, e.g. 0,0,0) as a mismatch under the rules above.

Reset
REQ-026 While rst=0, SHALL force state=SEARCH, run=0, exp=0, locked=0, error=0, err_sticky=0 and err_cnt=0, independent of clk.
REQ-027 SHALL resume operation from SEARCH on the first valid sample after the release edge, with no carry-over of earlier history.
REQ-028 SHALL apply reset asserted mid-sequence (including in LOST) immediately, with no error pulse generated.

Verification
REQ-029 Locking: rst released, valid samples 0,2,4 -> locked=1 after the 3rd sample; samples 6..14,0,2 -> locked stays 1, error never 1, err_cnt=0.
REQ-030 Glitch recovery: locked, samples 8,10,6,14 -> error pulse on the 6; state LOST with locked=1; the 14 restores LOCKED with no further error; err_cnt=1 and err_sticky=1.
REQ-031 Loss of lock: locked, samples 4,12,0 -> error on the 12 and error on the 0, state SEARCH, locked=0, err_cnt=2; then samples 2,4 -> locked=1 again.
REQ-032 Odd value: locked, sample 5 -> error=1, locked=0, run=0; the following 0,2,4 -> relock after the 4.
REQ-033 Stalls and reset: count_valid toggled 1/0 between the samples 0,2,4 -> locks after the 3rd valid sample; rst=0 then applied while locked with err_cnt=3 -> all outputs 0 immediately.
REQ-034 Saturation: 300 odd samples -> err_cnt=255, error pulses on every sample, err_sticky=1.
